load_data_unit: RTL
===================

# load_data_unit

Load-side counterpart to the store data merger: accepts a load request (byte address plus funct3), performs the word-aligned data-memory read with a request/acknowledge handshake, then extracts and sign- or zero-extends the addressed byte, half or word. It sits between the execute stage and data memory and returns a register-ready 32-bit value with a one-cycle valid pulse. It also reports faults: illegal funct3, misalignment and memory timeout.

## Interface
- TIMEOUT, 255: cycles to wait for mem_ack per read before faulting; 0 disables the timeout.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  load request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_addr  in  32  byte address
- req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_rd_en  out  1  memory read request, held until acknowledged
- mem_addr  out  32  word-aligned read address (bits [1:0] are 0)
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  32  read data, sampled when mem_ack=1
- resp_valid  out  1  one-cycle result pulse
- resp_data  out  32  extended load result; 0 when resp_fault=1
- resp_fault  out  1  qualifies resp_valid: illegal funct3, misaligned, or timeout

## Operation
- States:
  - IDLE: req_ready=1.
  - READ0: first word read.
  - READ1: second word read; used only with the split feature.
  - RESP: resp_valid=1.
- IDLE, req_valid=1: latch addr and funct3.
  - funct3 011, 110 or 111: go to RESP with fault=1. No memory access.
  - Otherwise: go to READ0.
- READ0 and READ1:
  - mem_rd_en=1; mem_addr = {addr[31:2],2'b00} in READ0, that value +4 in READ1 (wraps modulo 2^32).
  - On mem_ack, capture mem_rdata and advance.
- Timeout counter:
  - Clears on entry to each READ state and increments each cycle without ack.
  - When the count equals TIMEOUT, go to RESP with fault=1 and data=0.
- Extraction, off = addr[1:0]:
  - LB and LBU: byte at bits [off*8+7 : off*8], sign- or zero-extended.
  - LH and LHU: 16 bits starting at off*8, sign- or zero-extended.
  - LW: full word.
- RESP: resp_valid high for exactly one cycle, then IDLE. There is no response backpressure.
- Reset (asserted at any time, including mid-read):
  - State returns to IDLE; any in-flight read is abandoned and no response is produced.
  - Reset values: req_ready=1, mem_rd_en=0, mem_addr=0, resp_valid=0, resp_data=0, resp_fault=0.
  - mem_ack is ignored outside the READ states.
- resp_data and resp_fault hold their values until the next RESP.

## Timing
- A request is accepted on the clock edge where req_valid and req_ready are both 1 (cycle 0).
- mem_rd_en is high from cycle 1.
- If mem_ack arrives in cycle k (k≥1), resp_valid is high in cycle k+1.
  - Minimum request-to-response latency is 2 cycles; split reads add at least 1 more.
- Faults with no memory access (illegal funct3, misaligned without the feature): resp_valid in cycle 1.
- req_ready is low from cycle 1 until the cycle after resp_valid.
- Back-to-back: a new request can be accepted in the cycle after the RESP cycle.

## Configuration
- Macro: LOAD_MISALIGNED_EN.
- Undefined:
  - LH/LHU with addr[0]=1, or LW with addr[1:0]≠00, is misaligned: resp_fault=1 in cycle 1, no memory read.
  - READ1 is unreachable.
- Defined:
  - Misaligned loads that stay within one word (LH at offset 1) use a single read.
  - Word-crossing loads (LH at offset 3; LW at offsets 1–3) do READ0 then READ1.
  - Result is ({word1,word0} >> off*8), truncated to the access size and then extended.
  - A timeout in either read faults the whole load.

## Test plan
- LB at 0x103, mem_rdata=0x80FF_1234, ack in cycle 1 -> resp_data=0xFFFF_FF80, fault=0, resp_valid in cycle 2, mem_addr=0x100.
- LHU at 0x202, mem_rdata=0xBEEF_0000, ack after 3 wait cycles -> resp_data=0x0000_BEEF, resp_valid exactly 1 cycle, 4 cycles after mem_rd_en rises.
- funct3=011 -> resp_fault=1, resp_data=0, mem_rd_en never asserted; also LW at 0x101 without the macro -> fault=1 in cycle 1.
- With the macro: LW at 0x0FFF_FFFE, word0=0xAABB_CCDD, word1=0x1122_3344 -> mem_addr 0x0FFF_FFFC then 0x1000_0000, resp_data=0x3344_AABB.
- TIMEOUT=4 and mem_ack never asserted -> resp_valid with fault=1 at cycle 5; req_ready returns high the next cycle.
- reset_n pulsed low during READ0, then a late mem_ack -> no resp_valid, all outputs at reset values, next request served normally.

Source files
------------

// File: rtl/load_data_unit.sv
// Load data unit: word-aligned data-memory read with req/ack handshake, then byte/half/word
// extraction with sign/zero extension. Optional `LOAD_MISALIGNED_EN enables split reads.
module load_data_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_fault,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a rising edge with req_valid && req_ready; a memory
  // read completes on a rising edge with mem_rd_en && mem_ack; resp_valid is a one-cycle
  // pulse with no backpressure.

`ifdef LOAD_MISALIGNED_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ0 = 2'd1,
    READ1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic          split_q;
  logic [31:0]   word0_q;
  logic [CW-1:0] cnt;

  logic          legal_req;
  logic          misaligned_req;
  logic          crosses_req;
  logic          timeout_hit;
  logic [63:0]   dword;
  logic [31:0]   ext_data;

  function automatic logic is_legal(input logic [2:0] f3);
    is_legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == F3_LH || f3 == F3_LHU) is_misaligned = off[0];
    else if (f3 == F3_LW)            is_misaligned = (off != 2'b00);
    else                             is_misaligned = 1'b0;
  endfunction

  // True when the access spills past the end of the first word.
  function automatic logic crosses_word(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == F3_LH || f3 == F3_LHU) crosses_word = (off == 2'b11);
    else if (f3 == F3_LW)            crosses_word = (off != 2'b00);
    else                             crosses_word = 1'b0;
  endfunction

  function automatic logic [31:0] extract(input logic [63:0] dw, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [31:0] sh;
    sh = 32'(dw >> {off, 3'b000});
    case (f3)
      F3_LB:   extract = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   extract = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  extract = {24'h0, sh[7:0]};
      F3_LHU:  extract = {16'h0, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  always_comb begin
    legal_req      = is_legal(req_funct3);
    misaligned_req = !MisEn && is_misaligned(req_funct3, req_addr[1:0]);
    crosses_req    = MisEn && crosses_word(req_funct3, req_addr[1:0]);
    timeout_hit    = (TIMEOUT != 0) && (cnt == TMAX);
    dword          = (state == READ1) ? {mem_rdata, word0_q} : {32'h0, mem_rdata};
    ext_data       = extract(dword, off_q, f3_q);
  end

  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
      split_q    <= 1'b0;
      word0_q    <= 32'h0;
      cnt        <= '0;
      req_ready  <= 1'b1;
      mem_rd_en  <= 1'b0;
      mem_addr   <= 32'h0;
      resp_valid <= 1'b0;
      resp_data  <= 32'h0;
      resp_fault <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q     <= req_addr[1:0];
            f3_q      <= req_funct3;
            split_q   <= crosses_req;
            req_ready <= 1'b0;
            if (!legal_req || misaligned_req) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_data  <= 32'h0;
            end else begin
              state     <= READ0;
              mem_rd_en <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              cnt       <= '0;
            end
          end
        end
        READ0, READ1: begin
          if (mem_ack) begin
            if (state == READ0 && split_q) begin
              word0_q  <= mem_rdata;
              mem_addr <= mem_addr + 32'd4;
              cnt      <= '0;
              state    <= READ1;
            end else begin
              mem_rd_en  <= 1'b0;
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b0;
              resp_data  <= ext_data;
            end
          end else if (timeout_hit) begin
            // A timeout in either read abandons the whole load.
            mem_rd_en  <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
            resp_data  <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
